// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   MEM_* op/length codes : values driven on the IF_op / IF_len request port
//   fetch_entry_t        : one queue entry, {pc, inst}
package inst_fetch_pkg;

  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch stage, the memory controller and decode.
//   IF_op/IF_len/IF_addr : fetch request (fetch stage -> memory controller)
//   IF_rdy/IF_out        : returned word pulse (memory controller -> fetch stage)
//   id_valid/id_inst/id_pc : queue head offered to decode
//   id_ready             : decode accepts the head
// master = fetch stage side, slave = memory controller / decode side.
interface inst_fetch_if;

  logic [1:0]  IF_op;
  logic [1:0]  IF_len;
  logic [31:0] IF_addr;
  logic        IF_rdy;
  logic [31:0] IF_out;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output IF_op, IF_len, IF_addr,
    input  IF_rdy, IF_out,
    output id_valid, id_inst, id_pc,
    input  id_ready
  );

  modport slave (
    input  IF_op, IF_len, IF_addr,
    output IF_rdy, IF_out,
    input  id_valid, id_inst, id_pc,
    output id_ready
  );

endinterface

// File: rtl/inst_fetch_queue.sv
// inst_queue: in-order FIFO of {pc, inst} entries between fetch and decode.
//   clk_in, rst_n_in : clock, async active-low reset
//   push, push_data  : write an entry at the tail
//   pop              : retire the head entry
//   flush            : drop all entries (wins over push/pop)
//   full, empty      : occupancy flags
//   head_data        : entry at the head, read combinationally
// A push while full is accepted when a pop happens in the same cycle: the
// write lands in the slot the pop is freeing (tail == head when full).
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head_data
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  slots [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = slots[head];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        slots[tail] <= push_data;
        tail        <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the fetch PC, issues word loads, queues returned words and
// hands {pc, inst} to decode with a valid/ready handshake.
//   clk_in, rst_n_in : clock, async active-low reset
//   rdy_in           : global ready; low freezes every register
//   take_jmp         : redirect strobe, jmp_target is the new PC
//   fetch_bus        : IF_* request/response and id_* decode handshake
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        take_jmp,
  input  logic [31:0] jmp_target,
  inst_fetch_if.master fetch_bus
);

  logic [31:0]  fetch_pc;
  logic         q_full;
  logic         q_empty;
  logic         pop;
  logic         push;
  logic         flush;
  fetch_entry_t push_data;
  fetch_entry_t head;

  // The memory controller starts a fetch whenever it is idle, so the request
  // is permanently a word load; only the address moves.
  assign fetch_bus.IF_op   = MEM_LOAD;
  assign fetch_bus.IF_len  = MEM_WORD;
  assign fetch_bus.IF_addr = fetch_pc;

  assign fetch_bus.id_valid = !q_empty;
  assign fetch_bus.id_inst  = head.inst;
  assign fetch_bus.id_pc    = head.pc;

  assign pop   = !q_empty && fetch_bus.id_ready && rdy_in && !take_jmp;
  // A dropped word leaves fetch_pc untouched, so the same address is refetched.
  assign push  = rdy_in && !take_jmp && fetch_bus.IF_rdy && (!q_full || pop);
  assign flush = rdy_in && take_jmp;

  assign push_data = '{pc: fetch_pc, inst: fetch_bus.IF_out};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc <= RESET_PC;
    end else if (rdy_in) begin
      if (take_jmp)  fetch_pc <= jmp_target;
      else if (push) fetch_pc <= fetch_pc + INST_BYTES;
    end
  end

  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .full      (q_full),
    .empty     (q_empty),
    .head_data (head)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        take_jmp;
  logic [31:0] jmp_target;

  inst_fetch_if bus_if();

  inst_fetch #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .rdy_in     (rdy),
    .take_jmp   (take_jmp),
    .jmp_target (jmp_target),
    .fetch_bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: list of delivered-but-unconsumed {pc, inst} and the fetch PC.
  logic [63:0] model_q[$];
  logic [31:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle 1ns after.
  task automatic cyc(input logic r, input logic j, input logic [31:0] t,
                     input logic ifr, input logic idr);
    logic pop, acc;
    rdy = r; take_jmp = j; jmp_target = t;
    bus_if.IF_rdy = ifr; bus_if.IF_out = mem_word(model_pc); bus_if.id_ready = idr;
    @(posedge clk);
    if (r) begin
      if (j) begin
        model_q.delete();
        model_pc = t;
      end else begin
        pop = (model_q.size() != 0) && idr;
        acc = ifr && ((model_q.size() < DEPTH) || pop);
        if (pop) model_q.delete(0);
        if (acc) begin
          model_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_q.delete();
    model_pc = RST_PC;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; take_jmp = 1'b0; jmp_target = '0;
    bus_if.IF_rdy = 1'b0; bus_if.IF_out = '0; bus_if.id_ready = 1'b0;
    model_q.delete(); model_pc = RST_PC;
    #1;
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.id_valid); end
    n_tests++; if (bus_if.id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus_if.id_inst); end
    n_tests++; if (bus_if.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus_if.id_pc); end
    n_tests++; if (bus_if.IF_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus_if.IF_addr, RST_PC); end
    n_tests++; if (bus_if.IF_op !== MEM_LOAD) begin n_fail++; $display("FAIL reset_op: got %b want %b", bus_if.IF_op, MEM_LOAD); end
    n_tests++; if (bus_if.IF_len !== MEM_WORD) begin n_fail++; $display("FAIL reset_len: got %b want %b", bus_if.IF_len, MEM_WORD); end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    cyc(1, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0 || bus_if.id_inst !== 32'h1111_1111)
      begin n_fail++; $display("FAIL stream_first: got v=%b pc=%h inst=%h want 1/0/11111111", bus_if.id_valid, bus_if.id_pc, bus_if.id_inst); end
    n_tests++; if (bus_if.IF_addr !== 32'h4) begin n_fail++; $display("FAIL stream_addr4: got %h want 4", bus_if.IF_addr); end
    cyc(1, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h4 || bus_if.id_inst !== 32'h2222_2222)
      begin n_fail++; $display("FAIL stream_second: got v=%b pc=%h inst=%h want 1/4/22222222", bus_if.id_valid, bus_if.id_pc, bus_if.id_inst); end
    n_tests++; if (bus_if.IF_addr !== 32'h8) begin n_fail++; $display("FAIL stream_addr8: got %h want 8", bus_if.IF_addr); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", bus_if.id_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    n_tests++; if (bus_if.IF_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr_held: got %h want 8", bus_if.IF_addr); end
    n_tests++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head0: got v=%b pc=%h want 1/0", bus_if.id_valid, bus_if.id_pc); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_pc !== 32'h4 || bus_if.id_inst !== 32'h2222_2222) begin n_fail++; $display("FAIL bp_head4: got pc=%h inst=%h want 4/22222222", bus_if.id_pc, bus_if.id_inst); end
    cyc(1, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_pc !== 32'h8 || bus_if.id_inst !== 32'h3333_3333) begin n_fail++; $display("FAIL bp_refetch8: got pc=%h inst=%h want 8/33333333", bus_if.id_pc, bus_if.id_inst); end
    n_tests++; if (bus_if.IF_addr !== 32'hC) begin n_fail++; $display("FAIL bp_addr12: got %h want c", bus_if.IF_addr); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", bus_if.id_valid); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_pc !== 32'h4 || bus_if.IF_addr !== 32'hC) begin n_fail++; $display("FAIL full_pp_head: got pc=%h addr=%h want 4/c", bus_if.id_pc, bus_if.IF_addr); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h8) begin n_fail++; $display("FAIL full_pp_pushed: got v=%b pc=%h want 1/8", bus_if.id_valid, bus_if.id_pc); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_count: got %b want 0", bus_if.id_valid); end
  endtask

  task automatic test_redirect();
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 32'h100, 1, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_flush: got %b want 0", bus_if.id_valid); end
    n_tests++; if (bus_if.IF_addr !== 32'h100) begin n_fail++; $display("FAIL jmp_addr: got %h want 100", bus_if.IF_addr); end
    cyc(1, 0, 0, 1, 0);
    n_tests++; if (bus_if.id_pc !== 32'h100 || bus_if.id_inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL jmp_first: got pc=%h inst=%h want 100/%h", bus_if.id_pc, bus_if.id_inst, mem_word(32'h100)); end
  endtask

  task automatic test_pause();
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_valid !== 1'b1 || bus_if.id_pc !== 32'h0 || bus_if.IF_addr !== 32'h4) begin n_fail++; $display("FAIL pause_freeze: got v=%b pc=%h addr=%h want 1/0/4", bus_if.id_valid, bus_if.id_pc, bus_if.IF_addr); end
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0 || bus_if.IF_addr !== 32'h4) begin n_fail++; $display("FAIL pause_drop: got v=%b addr=%h want 0/4", bus_if.id_valid, bus_if.IF_addr); end
    cyc(1, 0, 0, 1, 0);
    n_tests++; if (bus_if.id_pc !== 32'h4 || bus_if.id_inst !== 32'h2222_2222 || bus_if.IF_addr !== 32'h8) begin n_fail++; $display("FAIL pause_refetch: got pc=%h inst=%h addr=%h want 4/22222222/8", bus_if.id_pc, bus_if.id_inst, bus_if.IF_addr); end
    cyc(1, 0, 0, 0, 1);
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL pause_once: got %b want 0", bus_if.id_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    model_pc = RST_PC;
    #1;
    n_tests++; if (bus_if.id_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus_if.id_valid); end
    n_tests++; if (bus_if.IF_addr !== RST_PC) begin n_fail++; $display("FAIL arst_addr: got %h want %h", bus_if.IF_addr, RST_PC); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 0, 1, 0);
    n_tests++; if (bus_if.id_pc !== RST_PC || bus_if.id_inst !== 32'h1111_1111 || bus_if.IF_addr !== 32'h4) begin n_fail++; $display("FAIL arst_restart: got pc=%h inst=%h addr=%h want 0/11111111/4", bus_if.id_pc, bus_if.id_inst, bus_if.IF_addr); end
  endtask

  task automatic test_random();
    logic r, j, ifr, idr;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom % 8) != 0;
      j   = ($urandom % 16) == 0;
      t   = $urandom;
      ifr = $urandom % 2;
      idr = ($urandom % 3) != 0;
      cyc(r, j, t, ifr, idr);
      n_tests++; if (bus_if.IF_addr !== model_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, bus_if.IF_addr, model_pc); end
      n_tests++; if (bus_if.id_valid !== (model_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus_if.id_valid, model_q.size() != 0); end
      if (model_q.size() != 0) begin
        n_tests++; if ({bus_if.id_pc, bus_if.id_inst} !== model_q[0]) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h_%h want %h", i, bus_if.id_pc, bus_if.id_inst, model_q[0]); end
      end
      n_tests++; if (bus_if.IF_op !== MEM_LOAD || bus_if.IF_len !== MEM_WORD) begin n_fail++; $display("FAIL rnd_oplen[%0d]: got %b/%b want %b/%b", i, bus_if.IF_op, bus_if.IF_len, MEM_LOAD, MEM_WORD); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_redirect();
    test_pause();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
